preimage_search: RTL and testbench

PREIMAGE_SEARCH -- requirements
Module: preimage_search

---
 rtl/preimage_search_pkg.sv | 17 +
 rtl/preimage_search_cell.sv | 22 ++
 rtl/preimage_search.sv | 117 +++++++++++
 tb/tb_preimage_search.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/preimage_search_pkg.sv
// Shared definitions for the preimage search block.
//   IDX_W  : width of the sweep index {a,b}
//   DATA_W : width of each cell operand and of the cell output
//   CNT_W  : width of the match counter (must hold 0..256)
//   state_t: controller states
package preimage_search_pkg;
  localparam int IDX_W  = 8;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/preimage_search_cell.sv
// Fixed 4-bit combinational cell function y = F(a,b).
//   a, b : operands
//   y    : cell output
module cell_func
  import preimage_search_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  logic w3;
  logic or_ab;

  assign w3    = a[1] | (a[2] & b[0]);
  // Shared term of y2/y3.
  assign or_ab = (a[3] | b[2]) & b[3];

  assign y[0] = ((a[0] ^ b[1]) | (a[0] & b[0])) & w3;
  assign y[1] = ~(w3 & b[1]) ^ b[2];
  assign y[2] = a[1] | ~(~a[3] | or_ab);
  assign y[3] = ~or_ab;
endmodule

// File: rtl/preimage_search.sv
// Exhaustive preimage search over the 4-bit cell function F.
// Sweeps idx = {a,b} from 0 to 255, presenting each (a,b) with F==target
// through a valid/ack handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start,target : launch a search for y == target (sampled in IDLE)
//   match_ack    : consumer accepts the presented match (HOLD only)
//   busy         : not IDLE
//   match_valid  : a_out/b_out hold a preimage
//   a_out, b_out : operands of the presented match
//   done         : one-cycle pulse at the end of a search
//   match_cnt    : matches found in the current or last search
module preimage_search
  import preimage_search_pkg::*;
#(
  parameter int FIRST_ONLY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] target,
  input  logic              match_ack,
  output logic              busy,
  output logic              match_valid,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt
);
  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [DATA_W-1:0] tgt, tgt_nx;
  logic [DATA_W-1:0] a_nx, b_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic [DATA_W-1:0] y;
  logic              hit;
  logic              idx_last;

  cell_func u_cell (
    .a (idx[IDX_W-1:DATA_W]),
    .b (idx[DATA_W-1:0]),
    .y (y)
  );

  assign hit      = (y == tgt);
  assign idx_last = (idx == {IDX_W{1'b1}});

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    tgt_nx   = tgt;
    a_nx     = a_out;
    b_nx     = b_out;
    cnt_nx   = match_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          tgt_nx   = target;
          idx_nx   = '0;
          cnt_nx   = '0;
          state_nx = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          a_nx     = idx[IDX_W-1:DATA_W];
          b_nx     = idx[DATA_W-1:0];
          cnt_nx   = match_cnt + CNT_W'(1);
          state_nx = HOLD;
        end else if (idx_last) begin
          state_nx = DONE;
        end else begin
          idx_nx = idx + IDX_W'(1);
        end
      end
      HOLD: begin
        // idx is only advanced when there is somewhere left to go, so it
        // never wraps past 255.
        if (match_ack) begin
          if ((FIRST_ONLY != 0) || idx_last) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx + IDX_W'(1);
            state_nx = SEARCH;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      tgt         <= '0;
      a_out       <= '0;
      b_out       <= '0;
      match_cnt   <= '0;
      busy        <= 1'b0;
      match_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      tgt         <= tgt_nx;
      a_out       <= a_nx;
      b_out       <= b_nx;
      match_cnt   <= cnt_nx;
      busy        <= (state_nx != IDLE);
      match_valid <= (state_nx == HOLD);
      done        <= (state_nx == DONE);
    end
  end
endmodule

// File: tb/tb_preimage_search.sv
// Self-checking bench for preimage_search: one instance enumerating all
// matches, one stopping after the first. Expected values come from a
// table-driven model of F built from the cell equations.
module tb_preimage_search;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] tgt0 = '0, tgt1 = '0;
  logic       ack0 = 1'b0, ack1 = 1'b0;
  logic       busy0, busy1, valid0, valid1, done0, done1;
  logic [3:0] a0, b0, a1, b1;
  logic [8:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  preimage_search #(.FIRST_ONLY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .target(tgt0), .match_ack(ack0),
    .busy(busy0), .match_valid(valid0), .a_out(a0), .b_out(b0),
    .done(done0), .match_cnt(cnt0)
  );

  preimage_search #(.FIRST_ONLY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .target(tgt1), .match_ack(ack1),
    .busy(busy1), .match_valid(valid1), .a_out(a1), .b_out(b1),
    .done(done1), .match_cnt(cnt1)
  );

  function automatic logic [3:0] f_ref(input logic [3:0] a, input logic [3:0] b);
    logic w3;
    logic [3:0] r;
    w3   = a[1] | (a[2] & b[0]);
    r[0] = ((a[0] ^ b[1]) | (a[0] & b[0])) & w3;
    r[1] = ~(w3 & b[1]) ^ b[2];
    r[2] = a[1] | ~(~a[3] | ((a[3] | b[2]) & b[3]));
    r[3] = ~((a[3] | b[2]) & b[3]);
    return r;
  endfunction

  // Table of F over the whole index space, ascending idx order.
  logic [3:0] f_tab [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full enumeration with ack tied high; optional disturbance of start/target.
  task automatic run_search0(input logic [3:0] t, input bit disturb, output int cnt_out);
    int exp_q[$];
    int got_q[$];
    int cyc, last_v, done_cyc;
    bit fin;
    logic [3:0] alt;
    for (int i = 0; i < 256; i++) if (f_tab[i] == t) exp_q.push_back(i);
    alt = t ^ 4'(1 + $urandom_range(0, 14));
    ack0 = 1'b1; tgt0 = t; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 0; last_v = -1; done_cyc = -1; fin = 0;
    while (!fin && cyc < 2000) begin
      if (disturb && cyc == 3)  begin start0 = 1'b1; tgt0 = alt; end
      if (disturb && cyc == 4)  start0 = 1'b0;
      if (disturb && cyc == 50) start0 = 1'b1;
      if (disturb && cyc == 52) start0 = 1'b0;
      @(negedge clk);
      cyc++;
      if (valid0) begin
        got_q.push_back({a0, b0});
        chk("pair_is_preimage", 32'(f_ref(a0, b0)), 32'(t));
        last_v = cyc;
      end
      if (done0) begin
        done_cyc = cyc;
        fin = 1;
      end
    end
    tgt0 = t;
    chk("search_finished", 32'(fin), 32'd1);
    chk("match_cnt", 32'(cnt0), 32'(exp_q.size()));
    chk("presented_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk("match_order", 32'(got_q[k]), 32'(exp_q[k]));
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1] == 255)
      chk("done_after_last_ack", 32'(done_cyc), 32'(last_v + 1));
    @(negedge clk);
    chk("done_single_pulse", 32'(done0), 32'd0);
    chk("idle_after_done", 32'(busy0), 32'd0);
    chk("cnt_holds", 32'(cnt0), 32'(exp_q.size()));
    cnt_out = cnt0;
  endtask

  initial begin
    int sum, c, hold, n, busy_seen, done_seen, k;
    bit fin;
    logic [3:0] t;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ii;
      ii = 8'(i);
      f_tab[i] = f_ref(ii[7:4], ii[3:0]);
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy0", 32'(busy0), 0);   chk("rst_valid0", 32'(valid0), 0);
    chk("rst_done0", 32'(done0), 0);   chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_a0", 32'(a0), 0);         chk("rst_b0", 32'(b0), 0);
    chk("rst_busy1", 32'(busy1), 0);   chk("rst_valid1", 32'(valid1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First match at idx 0 for target 1010, held until ack.
    n = 0;
    for (int i = 0; i < 256; i++) if (f_tab[i] == 4'b1010) n++;
    ack0 = 1'b0; tgt0 = 4'b1010; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("lat_busy", 32'(busy0), 1);
    chk("lat_valid_early", 32'(valid0), 0);
    @(negedge clk);
    chk("lat_valid", 32'(valid0), 1);
    chk("lat_a", 32'(a0), 0);
    chk("lat_b", 32'(b0), 0);
    chk("lat_cnt", 32'(cnt0), 1);
    hold = $urandom_range(1, 4);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(valid0), 1);
      chk("hold_ab", 32'({a0, b0}), 0);
    end
    ack0 = 1'b1;
    @(negedge clk);
    chk("valid_drops_after_ack", 32'(valid0), 0);
    k = 0; fin = 0;
    while (!fin && k < 2000) begin
      @(negedge clk);
      k++;
      if (done0) fin = 1;
    end
    chk("first_search_done", 32'(fin), 1);
    chk("first_search_cnt", 32'(cnt0), 32'(n));
    @(negedge clk);

    // Every target, ack high; counts must partition the index space.
    sum = 0;
    for (int ti = 0; ti < 16; ti++) begin
      run_search0(4'(ti), 1'b0, c);
      sum += c;
    end
    chk("count_sum", 32'(sum), 256);

    // FIRST_ONLY instance.
    ack1 = 1'b0; tgt1 = 4'b1010; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("fo_valid", 32'(valid1), 1);
    chk("fo_ab", 32'({a1, b1}), 0);
    repeat (2) begin
      @(negedge clk);
      chk("fo_hold", 32'(valid1), 1);
      chk("fo_no_done", 32'(done1), 0);
    end
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    chk("fo_valid_drop", 32'(valid1), 0);
    chk("fo_done", 32'(done1), 1);
    chk("fo_cnt", 32'(cnt1), 1);
    @(negedge clk);
    chk("fo_done_pulse", 32'(done1), 0);
    chk("fo_idle", 32'(busy1), 0);
    chk("fo_cnt_hold", 32'(cnt1), 1);

    // Reset mid-search; no resume, no done.
    t = 4'($urandom_range(0, 15));
    ack0 = 1'b1; tgt0 = t; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat ($urandom_range(95, 105)) @(negedge clk);
    chk("pre_reset_busy", 32'(busy0), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy0), 0);
    chk("mid_rst_cnt", 32'(cnt0), 0);
    chk("mid_rst_valid", 32'(valid0), 0);
    chk("mid_rst_done", 32'(done0), 0);
    rst_n = 1'b1;
    busy_seen = 0; done_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy0) busy_seen++;
      if (done0) done_seen++;
    end
    chk("no_resume", 32'(busy_seen), 0);
    chk("no_done_after_rst", 32'(done_seen), 0);

    // start/target disturbance during a search.
    t = 4'($urandom_range(0, 15));
    run_search0(t, 1'b1, c);
    // Target whose last preimage is idx 255.
    run_search0(f_tab[255], 1'b1, c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
